// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, lock-state encoding and counter helpers
// for the VGA timing generator and the sync decoder.
package vga_pkg;

  localparam int H_VISIBLE   = 640;
  localparam int H_FRONT     = 16;
  localparam int H_SYNC      = 96;
  localparam int H_TOTAL     = 800;
  localparam int V_VISIBLE   = 480;
  localparam int V_FRONT     = 10;
  localparam int V_SYNC      = 2;
  localparam int V_TOTAL     = 525;
  localparam int LOCK_FRAMES = 2;

  // Width of every measurement counter; all-ones doubles as the saturation value.
  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } lock_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_sync_meter.sv
// Registers one active-low sync input, flags its edges and measures its period
// and low width in units of 'step' (clocks for hsync, hsync falls for vsync).
module vga_sync_meter
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_n,
  input  logic             step,
  output logic             fall,
  output logic             rise,
  output logic             sat,
  output logic [CNT_W-1:0] total,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] width
);

  logic             sync_q;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt;

  assign fall  = !sync_q && sync_prev;
  assign rise  = sync_q && !sync_prev;
  assign sat   = (cnt == {CNT_W{1'b1}});
  // Count including this cycle's step, so a step coinciding with a fall is
  // charged to the period that fall closes.
  assign total = step ? sat_inc(cnt) : cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Idle-high reset so the first sample after reset cannot fake a fall.
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      period    <= '0;
      width     <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync_prev capture the old sync_q.
      sync_q    <= sync_n;
      sync_prev <= sync_q;
      if (fall) begin
        cnt    <= '0;
        period <= total;
        width  <= {{(CNT_W-1){1'b0}}, step};
      end else begin
        cnt <= total;
        if (!sync_q && step) width <= sat_inc(width);
      end
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing checker: locks onto the configured mode and
// regenerates pixel coordinates two clocks behind the generator's counters.
module vga_sync_decoder #(
  parameter int H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_pkg::H_FRONT,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_pkg::V_FRONT,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  output logic        locked,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic        visible,
  output logic [10:0] meas_h_total,
  output logic [10:0] meas_v_total,
  output logic [15:0] frame_err_cnt
);
  import vga_pkg::*;

  localparam logic [9:0] H_RELOAD = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] V_RELOAD = 10'(V_VISIBLE + V_FRONT);

  logic             h_fall, h_rise, h_sat;
  logic             v_fall, v_rise, unused_v_sat;
  logic [CNT_W-1:0] h_total, h_width, v_total, v_width;

  lock_state_t state, state_next;
  logic [3:0]  good_cnt, good_next;
  logic        err_inc;
  logic        frame_ok, line_bad, vwid_bad, frame_good;
  logic [9:0]  hpos, vpos;

  vga_sync_meter u_hmeter (
    .clk    (clk),
    .rst    (rst),
    .sync_n (hsync),
    .step   (1'b1),
    .fall   (h_fall),
    .rise   (h_rise),
    .sat    (h_sat),
    .total  (h_total),
    .period (meas_h_total),
    .width  (h_width)
  );

  vga_sync_meter u_vmeter (
    .clk    (clk),
    .rst    (rst),
    .sync_n (vsync),
    .step   (h_fall),
    .fall   (v_fall),
    .rise   (v_rise),
    .sat    (unused_v_sat),
    .total  (v_total),
    .period (meas_v_total),
    .width  (v_width)
  );

  assign line_bad   = (h_fall && h_total != CNT_W'(H_TOTAL)) ||
                      (h_rise && h_width != CNT_W'(H_SYNC));
  assign vwid_bad   = v_rise && v_width != CNT_W'(V_SYNC);
  // Same-cycle line errors still belong to the frame this vsync fall closes.
  assign frame_good = frame_ok && !line_bad && !vwid_bad &&
                      (v_total == CNT_W'(V_TOTAL));

  always_comb begin
    // NOTE: every variable is defaulted first so no branch can infer a latch.
    state_next = state;
    good_next  = good_cnt;
    err_inc    = 1'b0;
    unique case (state)
      SEARCH: begin
        if (v_fall) begin
          state_next = CHECK;
          good_next  = '0;
        end
      end
      CHECK: begin
        if (h_sat) begin
          state_next = SEARCH;
          err_inc    = 1'b1;
        end else if (v_fall) begin
          if (frame_good) begin
            good_next = good_cnt + 4'd1;
            if (good_next == 4'(LOCK_FRAMES)) state_next = LOCKED;
          end else begin
            good_next = '0;
            err_inc   = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (h_sat || (v_fall && !frame_good)) begin
          state_next = SEARCH;
          err_inc    = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SEARCH;
      good_cnt      <= '0;
      locked        <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      locked   <= (state_next == LOCKED);
      if (v_fall)                    frame_ok <= 1'b1;
      else if (line_bad || vwid_bad) frame_ok <= 1'b0;
      if (err_inc && frame_err_cnt != 16'hFFFF) frame_err_cnt <= frame_err_cnt + 16'd1;
    end
  end

  // Free-running position, re-anchored at every sync fall in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos <= '0;
      vpos <= '0;
    end else begin
      if (h_fall)                          hpos <= H_RELOAD;
      else if (hpos == 10'(H_TOTAL - 1))   hpos <= '0;
      else                                 hpos <= hpos + 10'd1;

      if (v_fall)                          vpos <= V_RELOAD;
      else if (!h_fall && hpos == 10'(H_TOTAL - 1))
        vpos <= (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
    end
  end

  assign px_x    = locked ? {1'b0, hpos[9:1]} : '0;
  assign px_y    = locked ? {1'b0, vpos[8:1]} : '0;
  assign visible = locked && (hpos < 10'(H_VISIBLE)) && (vpos < 10'(V_VISIBLE));

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder driven by a behavioural timing generator
// in a scaled-down mode; expected pixels are queued and compared 2 cycles later.
module tb_vga_sync_decoder;

  localparam int HV = 16, HF = 4, HS = 6, HT = 32;
  localparam int VV = 8, VF = 2, VS = 2, VT = 14;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync;
  logic        locked, visible;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic [10:0] meas_h_total, meas_v_total;
  logic [15:0] frame_err_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hsync         (hsync),
    .vsync         (vsync),
    .locked        (locked),
    .px_x          (px_x),
    .px_y          (px_y),
    .visible       (visible),
    .meas_h_total  (meas_h_total),
    .meas_v_total  (meas_v_total),
    .frame_err_cnt (frame_err_cnt)
  );

  typedef struct {
    int x;
    int y;
    bit vis;
  } pix_t;

  pix_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   gh = 0, gv = 0;
  bit   long_line = 0, short_sync = 0, short_frame = 0, freeze = 0, chk_pix = 0;
  bit   vs_prev_gen = 1, saw_vfall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive generator outputs, queue the expectation, clock, compare, advance.
  task automatic tick();
    pix_t e;
    int   len;
    hsync = freeze ? 1'b1 : !(gh >= HV + HF && gh < HV + HF + (short_sync ? HS - 1 : HS));
    vsync = !(gv >= VV + VF && gv < VV + VF + VS);
    saw_vfall   = vs_prev_gen && !vsync;
    vs_prev_gen = vsync;
    e.x   = gh >> 1;
    e.y   = (gv >> 1) & 255;
    e.vis = (gh < HV) && (gv < VV);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (chk_pix) begin
        check("pix_locked", locked, 1);
        check("px_x", px_x, e.x);
        check("px_y", px_y, e.y);
        check("visible", visible, e.vis);
      end
    end
    if (!freeze) begin
      len = long_line ? HT + 1 : HT;
      if (gh == len - 1) begin
        gh = 0;
        long_line  = 0;
        short_sync = 0;
        if (gv == (short_frame ? VT - 2 : VT - 1)) begin
          gv = 0;
          short_frame = 0;
        end else begin
          gv++;
        end
      end else begin
        gh++;
      end
    end
  endtask

  // Runs until the generator emits a vsync fall, then one more clock so the
  // decoder has acted on it.
  task automatic run_to_vfall();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!saw_vfall && n < 3 * FRAME);
    check("vfall_seen", saw_vfall, 1);
    tick();
  endtask

  task automatic seek(input int v, input int h);
    int n = 0;
    while (!(gv == v && gh == h) && n < 2 * FRAME) begin
      tick();
      n++;
    end
    check("seek", (gv == v && gh == h), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_px_x"}, px_x, 0);
    check({tag, "_px_y"}, px_y, 0);
    check({tag, "_visible"}, visible, 0);
    check({tag, "_meas_h"}, meas_h_total, 0);
    check({tag, "_meas_v"}, meas_v_total, 0);
    check({tag, "_err"}, frame_err_cnt, 0);
  endtask

  initial begin
    rst = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;

    // Loopback lock: partial frame, then two good frames.
    run_to_vfall(); check("lock_partial", locked, 0);
    run_to_vfall(); check("lock_good1", locked, 0);
    run_to_vfall(); check("lock_good2", locked, 1);
    check("meas_h", meas_h_total, HT);
    check("meas_v", meas_v_total, VT);
    check("err_clean", frame_err_cnt, 0);
    chk_pix = 1;
    run_to_vfall(); check("lock_hold", locked, 1);
    chk_pix = 0;

    // One long line while locked: noticed at the frame end, relock after 1+2.
    long_line = 1;
    seek(VV + VF + 2, 0);
    check("long_meas_h", meas_h_total, HT + 1);
    check("long_still_locked", locked, 1);
    run_to_vfall(); check("long_unlock", locked, 0);
    check("long_err", frame_err_cnt, 1);
    run_to_vfall(); check("long_partial", locked, 0);
    run_to_vfall(); check("long_good1", locked, 0);
    run_to_vfall(); check("long_relock", locked, 1);
    chk_pix = 1;
    run_to_vfall(); check("relock_hold", locked, 1);
    chk_pix = 0;

    // hsync stuck high: timeout after hcnt saturates, counted once.
    seek(0, 28);
    freeze = 1;
    repeat (1900) tick();
    check("hold_pre_timeout", locked, 1);
    repeat (200) tick();
    check("hold_timeout", locked, 0);
    check("hold_err", frame_err_cnt, 2);
    freeze = 0;
    run_to_vfall(); check("hold_check", locked, 0);
    check("hold_err_once", frame_err_cnt, 2);

    // Short hsync in CHECK: costs one extra frame before lock.
    short_sync = 1;
    run_to_vfall(); check("short_bad", locked, 0);
    check("short_err", frame_err_cnt, 3);
    run_to_vfall(); check("short_good1", locked, 0);
    run_to_vfall(); check("short_lock", locked, 1);

    // Single-cycle reset mid-frame while locked.
    seek(3, 2);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    run_to_vfall(); check("rst_partial", locked, 0);
    run_to_vfall(); check("rst_good1", locked, 0);
    run_to_vfall(); check("rst_relock", locked, 1);
    check("rst_meas_v", meas_v_total, VT);

    // Frame one line short.
    short_frame = 1;
    run_to_vfall();
    check("vshort_meas_v", meas_v_total, VT - 1);
    check("vshort_unlock", locked, 0);
    check("vshort_err", frame_err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
